// File: rtl/multi_port_g_aetcam_pipe.sv
// ---------------------------------------------------------------------------
// multi_port_g_aetcam_pipe
//
// Multi-port flip-flop ternary CAM with per-entry valid bits and a fixed
// two-stage search pipeline. Each port owns an independent write channel
// and an independent search channel.
//
// Parameters
//   NPORTS  number of write+search ports (1..8)
//   DEPTH   number of entries (power of two, >= 2)
//   WIDTH   pattern width in bits
//   AW      address width, derived from DEPTH
//
// Ports
//   clk     clock
//   rst     asynchronous active-high reset
//   wEn     per-port write enable
//   wInv    per-port invalidate qualifier (only meaningful with wEn)
//   wAddr   per-port write address
//   wPatt   per-port pattern to store
//   wMask   per-port mask to store, 1 = don't-care bit
//   sReq    per-port search request
//   sPatt   per-port search key
//   rValid  per-port result valid, one pulse per accepted request
//   match   per-port hit indicator
//   mAddr   per-port lowest matching entry index (0 on a miss)
//   vCount  number of valid entries after the current edge
//   mMulti  per-port multiple-hit flag (only with AETCAM_MULTI_HIT_EN)
//
// Optional feature macro: AETCAM_MULTI_HIT_EN
//   When defined, adds the mMulti output which flags searches that hit two
//   or more valid entries. When undefined the port and its logic are absent.
// ---------------------------------------------------------------------------
module multi_port_g_aetcam_pipe #(
    parameter int  NPORTS = 3,
    parameter int  DEPTH  = 64,
    parameter int  WIDTH  = 36,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NPORTS-1:0]             wEn,
    input  logic [NPORTS-1:0]             wInv,
    input  logic [NPORTS-1:0][AW-1:0]     wAddr,
    input  logic [NPORTS-1:0][WIDTH-1:0]  wPatt,
    input  logic [NPORTS-1:0][WIDTH-1:0]  wMask,
    input  logic [NPORTS-1:0]             sReq,
    input  logic [NPORTS-1:0][WIDTH-1:0]  sPatt,
    output logic [NPORTS-1:0]             rValid,
    output logic [NPORTS-1:0]             match,
    output logic [NPORTS-1:0][AW-1:0]     mAddr,
    output logic [AW:0]                   vCount
`ifdef AETCAM_MULTI_HIT_EN
    ,
    output logic [NPORTS-1:0]             mMulti
`endif
);

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] patt_q [DEPTH];
    logic [WIDTH-1:0] mask_q [DEPTH];

    // Resolved write request per entry
    logic [DEPTH-1:0] wr_hit;
    logic [DEPTH-1:0] wr_inv;
    logic [WIDTH-1:0] wr_patt [DEPTH];
    logic [WIDTH-1:0] wr_mask [DEPTH];
    logic [DEPTH-1:0] valid_d;
    logic [AW:0]      count_d;

    // Search pipeline
    logic [DEPTH-1:0]  hit_d [NPORTS];
    logic [DEPTH-1:0]  hit_q [NPORTS];
    logic [NPORTS-1:0] req_q;
    logic [AW-1:0]     enc   [NPORTS];
    logic [NPORTS-1:0] any_hit;

    // -----------------------------------------------------------------------
    // Write conflict resolution. Ports are scanned from the highest index
    // down so that the lowest-numbered port addressing an entry overwrites
    // every field chosen by higher ports: the lowest port wins entirely,
    // including the choice between write and invalidate.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wr_hit[i]  = 1'b0;
            wr_inv[i]  = 1'b0;
            wr_patt[i] = '0;
            wr_mask[i] = '0;
            for (int p = NPORTS - 1; p >= 0; p--) begin
                if (wEn[p] && (wAddr[p] == AW'(i))) begin
                    wr_hit[i]  = 1'b1;
                    wr_inv[i]  = wInv[p];
                    wr_patt[i] = wPatt[p];
                    wr_mask[i] = wMask[p];
                end
            end
        end
    end

    // Next-state valid vector and its population count. vCount is taken from
    // this vector so that simultaneous writes and invalidates on several
    // ports are all reflected in the same cycle.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = wr_hit[i] ? ~wr_inv[i] : valid_q[i];
            count_d    = count_d + {{AW{1'b0}}, valid_d[i]};
        end
    end

    // Entry array update. An invalidate only drops the valid bit; pattern
    // and mask keep their old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                patt_q[i] <= '0;
                mask_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit[i] && !wr_inv[i]) begin
                    patt_q[i] <= wr_patt[i];
                    mask_q[i] <= wr_mask[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vCount <= '0;
        end else begin
            vCount <= count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Search stage 1: compare every key against the array as it stands
    // before this edge's writes, then register the per-entry hit vectors.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                hit_d[p][i] = valid_q[i] &&
                              (((patt_q[i] ^ sPatt[p]) & ~mask_q[i]) == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
            for (int p = 0; p < NPORTS; p++) begin
                hit_q[p] <= '0;
            end
        end else begin
            req_q <= sReq;
            for (int p = 0; p < NPORTS; p++) begin
                hit_q[p] <= hit_d[p];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Search stage 2: priority encode (lowest index wins) and OR-reduce.
    // Scanning downward leaves the lowest set index in enc; a miss leaves 0.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            enc[p]     = '0;
            any_hit[p] = |hit_q[p];
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (hit_q[p][i]) begin
                    enc[p] = AW'(i);
                end
            end
        end
    end

    // Result registers. A bubble (no request in flight) holds match/mAddr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rValid <= '0;
            match  <= '0;
            mAddr  <= '0;
        end else begin
            rValid <= req_q;
            for (int p = 0; p < NPORTS; p++) begin
                if (req_q[p]) begin
                    match[p] <= any_hit[p];
                    mAddr[p] <= enc[p];
                end
            end
        end
    end

`ifdef AETCAM_MULTI_HIT_EN
    // Two or more hits: clearing the lowest set bit still leaves a bit set.
    logic [NPORTS-1:0] multi_hit;

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            multi_hit[p] = |(hit_q[p] & (hit_q[p] - DEPTH'(1)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mMulti <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (req_q[p]) begin
                    mMulti[p] <= multi_hit[p];
                end
            end
        end
    end
`endif

endmodule
